// File: rtl/eeg_sample_loader_pkg.sv
// Shared types and constants for the EEG sample loader front end of the CiM inference core.
package eeg_sample_loader_pkg;
  localparam int ADC_W  = 16;
  localparam int COMP_W = 22;
  localparam int ADDR_W = 16;

  localparam int NUM_SAMPLES_PER_EPOCH = 3840;  // 30 s at 128 Hz
  localparam int EEG_FRAC_BITS         = 10;
  localparam int EEG_SCALE_LOG2        = 5;

  typedef logic [ADC_W-1:0]         AdcData_t;
  typedef logic signed [COMP_W-1:0] CompFx_t;
  typedef logic [ADDR_W-1:0]        IntResAddr_t;

  localparam IntResAddr_t EEG_BASE_ADDR = '0;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } LoaderState_t;

  // Offset binary to two's complement is an MSB flip; the scale/frac change is a pure shift.
  function automatic CompFx_t adc_to_fx(input AdcData_t adc, input int shift);
    logic signed [ADC_W-1:0] s;
    s = {~adc[ADC_W-1], adc[ADC_W-2:0]};
    return CompFx_t'(s) <<< shift;
  endfunction
endpackage

// File: rtl/eeg_sample_loader_if.sv
// SoC sample input and intermediate-result memory write port of the EEG loader.
interface eeg_sample_loader_if
  import eeg_sample_loader_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_SAMPLES_PER_EPOCH
);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  logic             start_eeg_load;
  logic             new_eeg_data;
  AdcData_t         eeg;
  logic             mem_grant;
  logic             mem_write_en;
  logic             mem_chip_en;
  IntResAddr_t      mem_addr;
  CompFx_t          mem_data;
  DataWidth_t       mem_data_width;
  logic             loading;
  logic             load_done;
  logic             overflow;
  logic [CNT_W-1:0] sample_count;

  modport master (
    output start_eeg_load, new_eeg_data, eeg, mem_grant,
    input  mem_write_en, mem_chip_en, mem_addr, mem_data, mem_data_width,
           loading, load_done, overflow, sample_count
  );

  modport slave (
    input  start_eeg_load, new_eeg_data, eeg, mem_grant,
    output mem_write_en, mem_chip_en, mem_addr, mem_data, mem_data_width,
           loading, load_done, overflow, sample_count
  );
endinterface

// File: rtl/eeg_sample_fifo.sv
// 2-entry synchronous FIFO holding converted samples until the memory port grants a write.
module eeg_sample_fifo
  import eeg_sample_loader_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  CompFx_t din_i,
  output CompFx_t dout_o,
  output logic    full_o,
  output logic    empty_o
);
  CompFx_t    mem_q [2];
  logic       wptr_q, rptr_q;
  logic [1:0] cnt_q, cnt_d;

  // Caller only pushes when not full or popping, and only pops when not empty.
  assign cnt_d   = cnt_q + 2'(push_i) - 2'(pop_i);
  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/eeg_sample_loader.sv
// Captures one epoch of ADC samples, converts to compute fixed point and streams them into memory.
module eeg_sample_loader
  import eeg_sample_loader_pkg::*;
#(
  parameter int          NUM_SAMPLES    = NUM_SAMPLES_PER_EPOCH,
  parameter int          FRAC_BITS      = EEG_FRAC_BITS,
  parameter int          ADC_SCALE_LOG2 = EEG_SCALE_LOG2,
  parameter IntResAddr_t BASE_ADDR      = EEG_BASE_ADDR
) (
  input logic clk,
  input logic rst_n,
  eeg_sample_loader_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int SHIFT = FRAC_BITS - ADC_SCALE_LOG2;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t NUM  = cnt_t'(NUM_SAMPLES);
  localparam cnt_t LAST = cnt_t'(NUM_SAMPLES - 1);

  generate
    if (FRAC_BITS < ADC_SCALE_LOG2 || ADC_W + SHIFT > COMP_W) begin : g_bad_fmt
      $error("eeg_sample_loader: conversion does not fit the compute format");
    end
  endgenerate

  LoaderState_t state_q;
  cnt_t         sample_count_q, accepted_q;
  logic         overflow_q, load_done_q;

  logic    in_load, start, wr, push_req, push_ok, fifo_clr, fifo_full, fifo_empty;
  CompFx_t head, conv;

  assign in_load  = (state_q == ST_LOAD);
  assign start    = bus.start_eeg_load;
  // Writes are suppressed in an abort cycle so stale data never reaches memory.
  assign wr       = in_load && !start && !fifo_empty && bus.mem_grant;
  assign push_req = in_load && !start && bus.new_eeg_data && (accepted_q < NUM);
  assign push_ok  = push_req && (!fifo_full || wr);
  assign fifo_clr = start && (state_q != ST_DONE);
  assign conv     = adc_to_fx(bus.eeg, SHIFT);

  eeg_sample_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (push_ok),
    .pop_i   (wr),
    .din_i   (conv),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sample_count_q <= '0;
      accepted_q     <= '0;
      overflow_q     <= 1'b0;
      load_done_q    <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q        <= ST_LOAD;
            sample_count_q <= '0;
            accepted_q     <= '0;
            overflow_q     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            sample_count_q <= '0;
            accepted_q     <= '0;
            overflow_q     <= 1'b0;
          end else begin
            if (wr) begin
              sample_count_q <= sample_count_q + cnt_t'(1);
              if (sample_count_q == LAST) begin
                state_q     <= ST_DONE;
                load_done_q <= 1'b1;
              end
            end
            if (push_req) begin
              if (push_ok) accepted_q <= accepted_q + cnt_t'(1);
              else         overflow_q <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_write_en   = wr;
  assign bus.mem_chip_en    = wr;
  assign bus.mem_addr       = BASE_ADDR + IntResAddr_t'(sample_count_q);
  assign bus.mem_data       = head;
  assign bus.mem_data_width = SINGLE_WIDTH;
  assign bus.loading        = in_load;
  assign bus.load_done      = load_done_q;
  assign bus.overflow       = overflow_q;
  assign bus.sample_count   = sample_count_q;
endmodule

// File: tb/tb_eeg_sample_loader.sv
// Directed bench for eeg_sample_loader with a 4-sample epoch.
module tb_eeg_sample_loader;
  import eeg_sample_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eeg_sample_loader_if #(.NUM_SAMPLES(4)) bus ();

  eeg_sample_loader #(.NUM_SAMPLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int n_done  = 0;
  logic [15:0] wr_addr [$];

  always @(negedge clk) begin
    if (bus.mem_write_en === 1'b1) begin
      n_wr++;
      wr_addr.push_back(bus.mem_addr);
    end
    if (bus.load_done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] v);
    bus.eeg          = v;
    bus.new_eeg_data = 1'b1;
    tick();
    bus.new_eeg_data = 1'b0;
  endtask

  task automatic start();
    bus.start_eeg_load = 1'b1;
    tick();
    bus.start_eeg_load = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [15:0] a, input logic [21:0] d);
    chk({tag, ".wen"},  32'(bus.mem_write_en), 32'd1);
    chk({tag, ".cen"},  32'(bus.mem_chip_en), 32'd1);
    chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(a));
    chk({tag, ".data"}, {10'd0, bus.mem_data}, {10'd0, d});
  endtask

  logic [15:0] v2 [4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8001};
  logic [21:0] e2 [4] = '{22'd0, 22'd1048544, 22'h300000, 22'd32};

  initial begin
    bus.start_eeg_load = 1'b0;
    bus.new_eeg_data   = 1'b0;
    bus.eeg            = '0;
    bus.mem_grant      = 1'b0;
    #12;
    chk("rst.wen",   32'(bus.mem_write_en), 0);
    chk("rst.addr",  32'(bus.mem_addr), 0);
    chk("rst.data",  {10'd0, bus.mem_data}, 0);
    chk("rst.width", 32'(bus.mem_data_width), 0);
    chk("rst.load",  32'(bus.loading), 0);
    chk("rst.done",  32'(bus.load_done), 0);
    chk("rst.ovf",   32'(bus.overflow), 0);
    chk("rst.cnt",   32'(bus.sample_count), 0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a load
    bus.mem_grant = 1'b1;
    start();
    sample(16'h8001);
    sample(16'h8002);
    chk("t1.cnt_pre", 32'(bus.sample_count), 1);
    chk("t1.wen_pre", 32'(bus.mem_write_en), 1);
    rst_n = 1'b0;
    #1;
    chk("t1.wen",  32'(bus.mem_write_en), 0);
    chk("t1.cen",  32'(bus.mem_chip_en), 0);
    chk("t1.addr", 32'(bus.mem_addr), 0);
    chk("t1.data", {10'd0, bus.mem_data}, 0);
    chk("t1.load", 32'(bus.loading), 0);
    chk("t1.cnt",  32'(bus.sample_count), 0);
    rst_n = 1'b1;
    n_wr = 0;
    sample(16'h8003);
    sample(16'h8004);
    tick();
    chk("t1.idle_wr",   32'(n_wr), 0);
    chk("t1.idle_load", 32'(bus.loading), 0);
    chk("t1.idle_cnt",  32'(bus.sample_count), 0);

    // basic epoch with conversion corner values
    n_done = 0;
    start();
    chk("t2.load", 32'(bus.loading), 1);
    chk("t2.wen0", 32'(bus.mem_write_en), 0);
    for (int i = 0; i < 4; i++) begin
      sample(v2[i]);
      chk_wr($sformatf("t2.w%0d", i), 16'(i), e2[i]);
    end
    chk("t2.done_early", 32'(bus.load_done), 0);
    tick();
    chk("t2.done", 32'(bus.load_done), 1);
    chk("t2.cnt",  32'(bus.sample_count), 4);
    chk("t2.wen",  32'(bus.mem_write_en), 0);
    chk("t2.load_off", 32'(bus.loading), 0);
    tick();
    chk("t2.done_off", 32'(bus.load_done), 0);
    chk("t2.ndone", 32'(n_done), 1);

    // stall: third sample dropped
    start();
    bus.mem_grant = 1'b0;
    sample(16'h8001);
    sample(16'h8002);
    sample(16'h8003);
    chk("t3.ovf", 32'(bus.overflow), 1);
    chk("t3.wen_stall", 32'(bus.mem_write_en), 0);
    bus.mem_grant = 1'b1;
    #1;
    chk_wr("t3.w0", 16'd0, 22'd32);
    tick();
    chk_wr("t3.w1", 16'd1, 22'd64);
    tick();
    chk("t3.wen_idle", 32'(bus.mem_write_en), 0);
    chk("t3.load", 32'(bus.loading), 1);
    sample(16'h8004);
    chk_wr("t3.w2", 16'd2, 22'd128);
    sample(16'h8005);
    chk_wr("t3.w3", 16'd3, 22'd160);
    tick();
    chk("t3.done", 32'(bus.load_done), 1);
    chk("t3.ovf_sticky", 32'(bus.overflow), 1);
    tick();

    // push and pop on a full buffer
    start();
    chk("t4.ovf_clr", 32'(bus.overflow), 0);
    bus.mem_grant = 1'b0;
    sample(16'h8010);
    sample(16'h8020);
    chk("t4.wen_stall", 32'(bus.mem_write_en), 0);
    bus.mem_grant    = 1'b1;
    bus.eeg          = 16'h8030;
    bus.new_eeg_data = 1'b1;
    #1;
    chk_wr("t4.w0", 16'd0, 22'd512);
    tick();
    bus.new_eeg_data = 1'b0;
    chk("t4.ovf", 32'(bus.overflow), 0);
    chk_wr("t4.w1", 16'd1, 22'd1024);
    tick();
    chk_wr("t4.w2", 16'd2, 22'd1536);
    tick();
    chk("t4.wen_idle", 32'(bus.mem_write_en), 0);
    sample(16'h8040);
    chk_wr("t4.w3", 16'd3, 22'd2048);
    tick();
    chk("t4.done", 32'(bus.load_done), 1);
    chk("t4.ovf_end", 32'(bus.overflow), 0);
    tick();

    // abort mid-load with a simultaneous sample
    start();
    bus.mem_grant = 1'b0;
    sample(16'h8001);
    sample(16'h8002);
    sample(16'h8003);
    chk("t5.ovf_pre", 32'(bus.overflow), 1);
    bus.mem_grant      = 1'b1;
    bus.start_eeg_load = 1'b1;
    bus.eeg            = 16'h8100;
    bus.new_eeg_data   = 1'b1;
    #1;
    chk("t5.abort_wen", 32'(bus.mem_write_en), 0);
    tick();
    bus.start_eeg_load = 1'b0;
    bus.new_eeg_data   = 1'b0;
    chk("t5.ovf", 32'(bus.overflow), 0);
    chk("t5.cnt", 32'(bus.sample_count), 0);
    chk("t5.wen", 32'(bus.mem_write_en), 0);
    chk("t5.load", 32'(bus.loading), 1);
    for (int i = 0; i < 4; i++) begin
      sample(v2[i]);
      chk_wr($sformatf("t5.w%0d", i), 16'(i), e2[i]);
    end
    tick();
    chk("t5.done", 32'(bus.load_done), 1);
    tick();

    // pulses beyond the epoch length are ignored
    start();
    n_wr = 0;
    wr_addr.delete();
    for (int i = 0; i < 6; i++) sample(16'h9000 + 16'(i));
    tick();
    tick();
    chk("t6.nwr", 32'(n_wr), 4);
    chk("t6.nq", 32'(wr_addr.size()), 4);
    for (int i = 0; i < wr_addr.size(); i++) chk($sformatf("t6.a%0d", i), 32'(wr_addr[i]), 32'(i));
    chk("t6.ovf", 32'(bus.overflow), 0);
    chk("t6.cnt", 32'(bus.sample_count), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
